sys_reset_gen: RTL and testbench
================================

# sys_reset_gen

Reset sequencer fed by the system PLL: runs on the PLL system clock output and consumes the PLL lock flag. Produces the registered active-low system reset for the SoC. It holds reset until lock is stable for a programmable time. It filters lock glitches, accepts software and watchdog reset requests, and records the last reset cause.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for i_locked (≥2)
- HOLD_CYCLES, 1024, cycles of stable lock before reset release (≥1)
- LOCK_FILTER, 16, consecutive unlocked cycles in RUN that count as lock loss (≥1)

Ports:
- i_clk  in  1  system clock (PLL system output); single clock domain
- i_nrst  in  1  reset, asynchronous, active-low
- i_locked  in  1  PLL lock flag, asynchronous to i_clk
- i_sw_rst  in  1  software reset request, synchronous, level-sampled
- i_wdog_rst  in  1  watchdog reset request, synchronous, level-sampled
- o_sys_nrst  out  1  system reset, active-low, registered
- o_cause  out  2  last reset cause: 0 POR, 1 lock loss, 2 watchdog, 3 software
- o_rst_cnt  out  8  count of RUN exits since i_nrst, saturating at 255

## Operation
- i_locked passes through a SYNC_STAGES flop chain that resets to 0; its output is lock_s.
- FSM states and transitions:
  - WAIT_LOCK (reset state): lock_s=1 → HOLD, hold counter cleared to 0.
  - HOLD: counter +1 per cycle; lock_s=0 → WAIT_LOCK (no filtering); counter==HOLD_CYCLES-1 → RUN.
  - RUN: evaluated each cycle in this priority order:
    - filtered lock loss → WAIT_LOCK, cause 1
    - i_wdog_rst=1 → HOLD, counter 0, cause 2
    - i_sw_rst=1 → HOLD, counter 0, cause 3
- Lock filter in RUN:
  - filter counter +1 while lock_s=0; cleared when lock_s=1.
  - lock loss fires when lock_s=0 and counter==LOCK_FILTER-1, so lows shorter than LOCK_FILTER cycles are ignored.
  - filter counter is cleared on entry to RUN.
- i_sw_rst and i_wdog_rst are ignored outside RUN.
- o_sys_nrst is a flop loaded with (next_state==RUN), so it changes on the same edge as the state.
- o_cause is updated only on RUN exit. o_rst_cnt increments on every RUN exit and holds at 255.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No wrap is possible inside legal states.
- i_nrst assertion at any time, including mid-HOLD or in RUN, immediately forces:
  - WAIT_LOCK, all counters 0, sync chain 0
  - o_sys_nrst=0, o_cause=0, o_rst_cnt=0

## Timing
- Reset values: o_sys_nrst=0, o_cause=0, o_rst_cnt=0, state WAIT_LOCK.
- Release latency: i_locked high and stable → o_sys_nrst=1 after exactly SYNC_STAGES+1+HOLD_CYCLES rising edges.
- Lock-loss latency: i_locked low in RUN → o_sys_nrst=0 after SYNC_STAGES+LOCK_FILTER edges.
- Sw/watchdog reset: o_sys_nrst=0 on the first edge sampling the request, then re-released HOLD_CYCLES edges later provided lock_s stays 1.
- Simultaneous events in RUN: priority is lock loss > watchdog > software. Only the highest-priority cause is recorded, and o_rst_cnt increments by 1.
- Request held high through HOLD: no effect until RUN is reached. A level still high on the first RUN cycle re-triggers immediately.

## Configuration
- SYS_RESET_GEN_WDOG_EN defined: i_wdog_rst is active as described, and cause 2 is reportable.
- SYS_RESET_GEN_WDOG_EN undefined:
  - i_wdog_rst is ignored; the port remains, unused.
  - o_cause never takes value 2.
  - RUN priority becomes lock loss > software.

## Test plan
Params SYNC_STAGES=2, HOLD_CYCLES=16, LOCK_FILTER=4 unless noted.
- POR: i_nrst low 3 cycles, then high, with i_locked high from before edge 1 → o_sys_nrst rises after edge 19; o_cause=0, o_rst_cnt=0.
- Lock glitch: in RUN, i_locked low 3 cycles → o_sys_nrst stays 1. Low 4 cycles → o_sys_nrst=0 at edge 6 after the drop; o_cause=1, o_rst_cnt=1.
- Software reset: 1-cycle i_sw_rst in RUN → o_sys_nrst=0 next edge, 1 again 16 edges later; o_cause=3.
- Simultaneous: i_wdog_rst=i_sw_rst=1 in the same RUN cycle with macro defined → o_cause=2, o_rst_cnt +1. With macro undefined → o_cause=3.
- Lock drop in HOLD: i_locked low 1 cycle at HOLD count 10 → returns to WAIT_LOCK; full 16-cycle hold restarts after relock.
- Saturation and async reset: 300 sw resets → o_rst_cnt=255. Then i_nrst pulsed mid-HOLD → all outputs return to 0 immediately, asynchronously.

Source files
------------

// File: rtl/sys_reset_gen.sv
// Reset sequencer on the PLL system clock: holds o_sys_nrst low until lock is stable, filters lock glitches,
// honours software/watchdog requests and logs the last cause. Define SYS_RESET_GEN_WDOG_EN to enable i_wdog_rst.
module sys_reset_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int LOCK_FILTER = 16
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_locked,
    input  logic       i_sw_rst,
    input  logic       i_wdog_rst,
    output logic       o_sys_nrst,
    output logic [1:0] o_cause,
    output logic [7:0] o_rst_cnt
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);

    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_WDOG = 2'd2;
    localparam logic [1:0] CAUSE_SW   = 2'd3;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lock_s;
    state_t                 state_r;
    state_t                 next_state_s;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [HOLD_W-1:0]      hold_cnt_nxt_s;
    logic [FILT_W-1:0]      filt_cnt_r;
    logic [FILT_W-1:0]      filt_cnt_nxt_s;
    logic                   run_exit_s;
    logic [1:0]             exit_cause_s;
    logic                   wdog_req_s;

`ifdef SYS_RESET_GEN_WDOG_EN
    assign wdog_req_s = i_wdog_rst;
`else
    logic wdog_unused_s;
    assign wdog_unused_s = i_wdog_rst;
    assign wdog_req_s    = 1'b0;
`endif

    assign lock_s = sync_r[SYNC_STAGES-1];

    // Lock flag synchronizer; clears to "unlocked" so a reset never looks locked.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_locked};
        end
    end

    // Next-state, counter and exit-cause decision.
    always_comb begin
        next_state_s   = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        filt_cnt_nxt_s = filt_cnt_r;
        run_exit_s     = 1'b0;
        exit_cause_s   = o_cause;
        case (state_r)
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state_s   = HOLD;
                    hold_cnt_nxt_s = '0;
                end else begin
                    next_state_s   = WAIT_LOCK;
                end
            end
            HOLD: begin
                // Any unlock during HOLD restarts the wait; no filtering here.
                if (!lock_s) begin
                    next_state_s   = WAIT_LOCK;
                    hold_cnt_nxt_s = '0;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    next_state_s   = RUN;
                    filt_cnt_nxt_s = '0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s && (filt_cnt_r == FILT_LAST)) begin
                    next_state_s   = WAIT_LOCK;
                    hold_cnt_nxt_s = '0;
                    run_exit_s     = 1'b1;
                    exit_cause_s   = CAUSE_LOCK;
                end else if (wdog_req_s) begin
                    next_state_s   = HOLD;
                    hold_cnt_nxt_s = '0;
                    run_exit_s     = 1'b1;
                    exit_cause_s   = CAUSE_WDOG;
                end else if (i_sw_rst) begin
                    next_state_s   = HOLD;
                    hold_cnt_nxt_s = '0;
                    run_exit_s     = 1'b1;
                    exit_cause_s   = CAUSE_SW;
                end else if (lock_s) begin
                    filt_cnt_nxt_s = '0;
                end else begin
                    filt_cnt_nxt_s = filt_cnt_r + 1'b1;
                end
            end
            default: begin
                next_state_s   = WAIT_LOCK;
                hold_cnt_nxt_s = '0;
                filt_cnt_nxt_s = '0;
            end
        endcase
    end

    // State, counters and registered outputs; o_sys_nrst tracks the state edge exactly.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r    <= WAIT_LOCK;
            hold_cnt_r <= '0;
            filt_cnt_r <= '0;
            o_sys_nrst <= 1'b0;
            o_cause    <= 2'd0;
            o_rst_cnt  <= 8'd0;
        end else begin
            state_r    <= next_state_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            filt_cnt_r <= filt_cnt_nxt_s;
            o_sys_nrst <= (next_state_s == RUN);
            if (run_exit_s) begin
                o_cause <= exit_cause_s;
                if (o_rst_cnt != 8'd255) begin
                    o_rst_cnt <= o_rst_cnt + 8'd1;
                end else begin
                    o_rst_cnt <= o_rst_cnt;
                end
            end else begin
                o_cause   <= o_cause;
                o_rst_cnt <= o_rst_cnt;
            end
        end
    end

endmodule

// File: tb/tb_sys_reset_gen.sv
// Scoreboard bench for sys_reset_gen: stimulus queues each expected output change with its cycle,
// a monitor pops and compares whenever the output triple changes.
module tb_sys_reset_gen;

    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 16;
    localparam int LOCK_FILTER = 4;

    typedef struct {
        int         cyc;
        logic       nrst;
        logic [1:0] cause;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       nrst;
    logic       locked;
    logic       sw_rst;
    logic       wdog_rst;
    logic       sys_nrst;
    logic [1:0] cause;
    logic [7:0] rst_cnt;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model_cnt;
    logic [1:0] simul_cause;

    sys_reset_gen #(
        .SYNC_STAGES(SYNC_STAGES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .LOCK_FILTER(LOCK_FILTER)
    ) dut (
        .i_clk     (clk),
        .i_nrst    (nrst),
        .i_locked  (locked),
        .i_sw_rst  (sw_rst),
        .i_wdog_rst(wdog_rst),
        .o_sys_nrst(sys_nrst),
        .o_cause   (cause),
        .o_rst_cnt (rst_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic n, input logic [1:0] ca, input logic [7:0] cn);
        exp_t e;
        e.cyc   = c;
        e.nrst  = n;
        e.cause = ca;
        e.cnt   = cn;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_pulse(input logic sw, input logic wd);
        sw_rst   = sw;
        wdog_rst = wd;
        tick(1);
        sw_rst   = 1'b0;
        wdog_rst = 1'b0;
    endtask

    // Monitor: every change of the output triple must match the next queued expectation.
    initial begin : monitor
        logic [10:0] prev;
        logic [10:0] cur;
        exp_t        e;
        @(negedge clk);
        prev = {sys_nrst, cause, rst_cnt};
        forever begin
            @(negedge clk);
            cur = {sys_nrst, cause, rst_cnt};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_change: got nrst=%0b cause=%0d cnt=%0d at cycle %0d, required no change",
                             sys_nrst, cause, rst_cnt, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("sys_nrst", {31'd0, sys_nrst}, {31'd0, e.nrst});
                    check("cause", {30'd0, cause}, {30'd0, e.cause});
                    check("rst_cnt", {24'd0, rst_cnt}, {24'd0, e.cnt});
                end
                prev = cur;
            end
        end
    end

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int c;
        nrst      = 1'b1;
        locked    = 1'b1;
        sw_rst    = 1'b0;
        wdog_rst  = 1'b0;
        model_cnt = 8'd0;
        #1 nrst = 1'b0;
        tick(3);
        check("por_sys_nrst", {31'd0, sys_nrst}, 32'd0);
        check("por_cause", {30'd0, cause}, 32'd0);
        check("por_rst_cnt", {24'd0, rst_cnt}, 32'd0);

        // POR release: SYNC_STAGES + 1 + HOLD_CYCLES edges
        expect_at(cyc + 19, 1'b1, 2'd0, 8'd0);
        nrst = 1'b1;
        tick(25);

        // 3-cycle lock glitch is filtered out
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(10);

        // 4-cycle low is a lock loss, then relock and full hold
        model_cnt = model_cnt + 8'd1;
        expect_at(cyc + 6, 1'b0, 2'd1, model_cnt);
        expect_at(cyc + 23, 1'b1, 2'd1, model_cnt);
        locked = 1'b0;
        tick(4);
        locked = 1'b1;
        tick(25);

        // software reset
        model_cnt = model_cnt + 8'd1;
        expect_at(cyc + 1, 1'b0, 2'd3, model_cnt);
        expect_at(cyc + 17, 1'b1, 2'd3, model_cnt);
        req_pulse(1'b1, 1'b0);
        tick(19);

        // simultaneous watchdog + software
`ifdef SYS_RESET_GEN_WDOG_EN
        simul_cause = 2'd2;
`else
        simul_cause = 2'd3;
`endif
        model_cnt = model_cnt + 8'd1;
        expect_at(cyc + 1, 1'b0, simul_cause, model_cnt);
        expect_at(cyc + 17, 1'b1, simul_cause, model_cnt);
        req_pulse(1'b1, 1'b1);
        tick(19);

        // watchdog alone: active only when enabled
`ifdef SYS_RESET_GEN_WDOG_EN
        model_cnt = model_cnt + 8'd1;
        expect_at(cyc + 1, 1'b0, 2'd2, model_cnt);
        expect_at(cyc + 17, 1'b1, 2'd2, model_cnt);
`endif
        req_pulse(1'b0, 1'b1);
        tick(19);

        // lock drop at HOLD count 10 restarts the full hold after relock
        c = cyc;
        model_cnt = model_cnt + 8'd1;
        expect_at(c + 1, 1'b0, 2'd3, model_cnt);
        expect_at(c + 29, 1'b1, 2'd3, model_cnt);
        req_pulse(1'b1, 1'b0);
        tick(8);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(25);

        // 300 software resets saturate the counter
        for (int i = 0; i < 300; i++) begin
            if (model_cnt != 8'd255) model_cnt = model_cnt + 8'd1;
            expect_at(cyc + 1, 1'b0, 2'd3, model_cnt);
            expect_at(cyc + 17, 1'b1, 2'd3, model_cnt);
            req_pulse(1'b1, 1'b0);
            tick(16);
        end
        check("rst_cnt_saturated", {24'd0, rst_cnt}, 32'd255);

        // async reset mid-HOLD clears everything at once
        expect_at(cyc + 1, 1'b0, 2'd3, 8'd255);
        req_pulse(1'b1, 1'b0);
        tick(4);
        expect_at(cyc + 1, 1'b0, 2'd0, 8'd0);
        #2 nrst = 1'b0;
        #1;
        check("async_sys_nrst", {31'd0, sys_nrst}, 32'd0);
        check("async_cause", {30'd0, cause}, 32'd0);
        check("async_rst_cnt", {24'd0, rst_cnt}, 32'd0);
        tick(2);
        expect_at(cyc + 19, 1'b1, 2'd0, 8'd0);
        nrst = 1'b1;
        tick(25);

        check("pending_expectations", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
